// File: rtl/pps_div_controller.sv
// Sequences one PPS divider channel: divides PPS edges, delays by phase_us, emits a width_us pulse.
// Latency: pulse rises phase_us*CLK_PER_US+1 cycles after the PPS edge cycle; no backpressure.
module pps_div_controller #(
  parameter int CLK_PER_US = 10
) (
  input  logic        i_clk_10,
  input  logic        i_rst,
  input  logic        i_pps,
  input  logic        i_arm,
  input  logic        i_disarm,
  input  logic [7:0]  i_periodic_true,
  input  logic [7:0]  i_div_number,
  input  logic [31:0] i_phase_us,
  input  logic [7:0]  i_width_us,
  input  logic [7:0]  i_start,
  input  logic [7:0]  i_stop,
  output logic        o_pulse,
  output logic        o_active,
  output logic        o_done,
  output logic        o_overrun,
  output logic [7:0]  o_pps_count
);

  localparam int PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_PER_US - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_PPS,
    S_PHASE,
    S_HIGH,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic          pps_prev_q, pps_prev_d;
  logic          periodic_q, periodic_d;
  logic [7:0]    div_q, div_d;
  logic [31:0]   phase_q, phase_d;
  logic [7:0]    width_q, width_d;
  logic [7:0]    start_q, start_d;
  logic [7:0]    stop_q, stop_d;
  logic [7:0]    n_q, n_d;
  logic [7:0]    div_cnt_q, div_cnt_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [31:0]   us_q, us_d;
  logic          last_q, last_d;
  logic          pulse_q, pulse_d;
  logic          overrun_q, overrun_d;

  logic          pps_rise;
  logic [7:0]    n_inc;
  logic [7:0]    div_n;
  logic [7:0]    div_cnt_nxt;
  logic          eligible;
  logic          trig;
  logic          at_stop;
  logic          last_now;
  logic          presc_wrap;
  logic          phase_end;
  logic          high_end;

  assign pps_rise    = i_pps & ~pps_prev_q;
  assign n_inc       = (n_q == 8'hFF) ? n_q : n_q + 8'd1;
  assign div_n       = (div_q == 8'd0) ? 8'd1 : div_q;
  assign div_cnt_nxt = ((div_cnt_q + 8'd1) == div_n) ? 8'd0 : div_cnt_q + 8'd1;
  assign eligible    = periodic_q | ((n_inc >= start_q) & (n_inc <= stop_q));
  assign trig        = eligible & (div_cnt_q == 8'd0);
  assign at_stop     = ~periodic_q & (n_inc == stop_q);
  // A stop-index edge seen during PHASE/HIGH must end the run even on the expiry cycle itself.
  assign last_now    = last_q | (pps_rise & at_stop);
  assign presc_wrap  = (presc_q == PRESC_MAX);
  assign phase_end   = presc_wrap & (us_q == (phase_q - 32'd1));
  assign high_end    = presc_wrap & (us_q == ({24'd0, width_q} - 32'd1));

  always_comb begin
    state_d    = state_q;
    pps_prev_d = i_pps;
    periodic_d = periodic_q;
    div_d      = div_q;
    phase_d    = phase_q;
    width_d    = width_q;
    start_d    = start_q;
    stop_d     = stop_q;
    n_d        = n_q;
    div_cnt_d  = div_cnt_q;
    presc_d    = presc_q;
    us_d       = us_q;
    last_d     = last_q;
    overrun_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_arm && !i_disarm) begin
          periodic_d = |i_periodic_true;
          div_d      = i_div_number;
          phase_d    = i_phase_us;
          width_d    = i_width_us;
          start_d    = i_start;
          stop_d     = i_stop;
          n_d        = 8'd0;
          div_cnt_d  = 8'd0;
          last_d     = 1'b0;
          presc_d    = '0;
          us_d       = 32'd0;
          if (!(|i_periodic_true) && (i_stop < i_start)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT_PPS;
          end
        end
      end

      S_WAIT_PPS: begin
        if (pps_rise) begin
          n_d = n_inc;
          if (eligible) begin
            div_cnt_d = div_cnt_nxt;
          end
          if (trig) begin
            last_d  = at_stop;
            presc_d = '0;
            us_d    = 32'd0;
            // Zero phase skips PHASE so the pulse can rise the cycle after the edge.
            if (phase_q != 32'd0) begin
              state_d = S_PHASE;
            end else if (width_q != 8'd0) begin
              state_d = S_HIGH;
            end else if (at_stop) begin
              state_d = S_DONE;
            end
          end else if (at_stop) begin
            state_d = S_DONE;
          end
        end
      end

      S_PHASE, S_HIGH: begin
        if (presc_wrap) begin
          presc_d = '0;
          us_d    = us_q + 32'd1;
        end else begin
          presc_d = presc_q + 1'b1;
        end
        if (pps_rise) begin
          n_d       = n_inc;
          overrun_d = trig;
          if (eligible) begin
            div_cnt_d = div_cnt_nxt;
          end
          if (at_stop) begin
            last_d = 1'b1;
          end
        end
        if (state_q == S_PHASE && phase_end) begin
          presc_d = '0;
          us_d    = 32'd0;
          if (width_q != 8'd0) begin
            state_d = S_HIGH;
          end else begin
            state_d = last_now ? S_DONE : S_WAIT_PPS;
          end
        end
        if (state_q == S_HIGH && high_end) begin
          state_d = last_now ? S_DONE : S_WAIT_PPS;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (i_disarm) begin
      state_d = S_IDLE;
    end
  end

  assign pulse_d = (state_d == S_HIGH);

  always_ff @(posedge i_clk_10) begin
    if (!i_rst) begin
      state_q    <= S_IDLE;
      pps_prev_q <= 1'b0;
      periodic_q <= 1'b0;
      div_q      <= 8'd0;
      phase_q    <= 32'd0;
      width_q    <= 8'd0;
      start_q    <= 8'd0;
      stop_q     <= 8'd0;
      n_q        <= 8'd0;
      div_cnt_q  <= 8'd0;
      presc_q    <= '0;
      us_q       <= 32'd0;
      last_q     <= 1'b0;
      pulse_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pps_prev_q <= pps_prev_d;
      periodic_q <= periodic_d;
      div_q      <= div_d;
      phase_q    <= phase_d;
      width_q    <= width_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      n_q        <= n_d;
      div_cnt_q  <= div_cnt_d;
      presc_q    <= presc_d;
      us_q       <= us_d;
      last_q     <= last_d;
      pulse_q    <= pulse_d;
      overrun_q  <= overrun_d;
    end
  end

  assign o_pulse     = pulse_q;
  assign o_active    = (state_q != S_IDLE);
  assign o_done      = (state_q == S_DONE);
  assign o_overrun   = overrun_q;
  assign o_pps_count = n_q;

endmodule
